// File: rtl/panel_input_cond.sv
// panel_input_cond: front-panel conditioner ahead of the LED pattern stage.
// Synchronises and debounces the mode switches and the continue key, and
// generates the periodic step tick.
// Ports:
//   clk, reset            : clock, async active-high reset
//   sw_raw[1:0], key_raw  : raw async inputs (key active-low)
//   tick_en               : tick counter run enable
//   sw[1:0], contin       : debounced levels (contin active-low)
//   contin_press/_release : one-cycle button strobes
//   sw_change, tick       : one-cycle switch-update and step strobes
module panel_input_cond #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_CYCLES     = 50000000,
  parameter int CNT_W           = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  input  logic       key_raw,
  input  logic       tick_en,
  output logic [1:0] sw,
  output logic       contin,
  output logic       contin_press,
  output logic       contin_release,
  output logic       sw_change,
  output logic       tick
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TK_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT
  } btn_st_t;

  logic [1:0] sw_m_q, sw_s_q, sw_p_q;
  logic       key_m_q, key_s_q;

  logic [1:0]       sw_q, sw_d;
  logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic             sw_chg_q, sw_chg_d;

  btn_st_t          st_q, st_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic             contin_q, contin_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  logic [CNT_W-1:0] t_cnt_q, t_cnt_d;
  logic             tick_q, tick_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_m_q   <= 2'b00;
      sw_s_q   <= 2'b00;
      sw_p_q   <= 2'b00;
      key_m_q  <= 1'b1;
      key_s_q  <= 1'b1;
      sw_q     <= 2'b00;
      sw_cnt_q <= '0;
      sw_chg_q <= 1'b0;
      st_q     <= IDLE;
      b_cnt_q  <= '0;
      contin_q <= 1'b1;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      t_cnt_q  <= '0;
      tick_q   <= 1'b0;
    end else begin
      sw_m_q   <= sw_raw;
      sw_s_q   <= sw_m_q;
      sw_p_q   <= sw_s_q;
      key_m_q  <= key_raw;
      key_s_q  <= key_m_q;
      sw_q     <= sw_d;
      sw_cnt_q <= sw_cnt_d;
      sw_chg_q <= sw_chg_d;
      st_q     <= st_d;
      b_cnt_q  <= b_cnt_d;
      contin_q <= contin_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      t_cnt_q  <= t_cnt_d;
      tick_q   <= tick_d;
    end
  end

  // A fresh sw_s value (differs from last cycle) restarts the count at 1.
  always_comb begin
    sw_d     = sw_q;
    sw_cnt_d = '0;
    sw_chg_d = 1'b0;
    if (sw_s_q != sw_q) begin
      if (sw_s_q != sw_p_q) begin
        sw_cnt_d = ONE;
      end else if (sw_cnt_q == DB_LAST) begin
        sw_d     = sw_s_q;
        sw_chg_d = 1'b1;
      end else begin
        sw_cnt_d = sw_cnt_q + ONE;
      end
    end
  end

  always_comb begin
    st_d     = st_q;
    b_cnt_d  = b_cnt_q;
    contin_d = contin_q;
    press_d  = 1'b0;
    rel_d    = 1'b0;
    case (st_q)
      IDLE: begin
        contin_d = 1'b1;
        b_cnt_d  = '0;
        if (!key_s_q) begin
          st_d    = PRESS_WAIT;
          b_cnt_d = ONE;
        end
      end
      PRESS_WAIT: begin
        if (key_s_q) begin
          st_d    = IDLE;
          b_cnt_d = '0;
        end else if (b_cnt_q == DB_LAST) begin
          st_d     = PRESSED;
          b_cnt_d  = '0;
          contin_d = 1'b0;
          press_d  = 1'b1;
        end else begin
          b_cnt_d = b_cnt_q + ONE;
        end
      end
      PRESSED: begin
        contin_d = 1'b0;
        b_cnt_d  = '0;
        if (key_s_q) begin
          st_d    = RELEASE_WAIT;
          b_cnt_d = ONE;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s_q) begin
          st_d    = PRESSED;
          b_cnt_d = '0;
        end else if (b_cnt_q == DB_LAST) begin
          st_d     = IDLE;
          b_cnt_d  = '0;
          contin_d = 1'b1;
          rel_d    = 1'b1;
        end else begin
          b_cnt_d = b_cnt_q + ONE;
        end
      end
      default: begin
        st_d     = IDLE;
        b_cnt_d  = '0;
        contin_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    t_cnt_d = t_cnt_q;
    tick_d  = 1'b0;
    if (tick_en) begin
      if (t_cnt_q == TK_LAST) begin
        t_cnt_d = '0;
        tick_d  = 1'b1;
      end else begin
        t_cnt_d = t_cnt_q + ONE;
      end
    end
  end

  assign sw             = sw_q;
  assign contin         = contin_q;
  assign contin_press   = press_q;
  assign contin_release = rel_q;
  assign sw_change      = sw_chg_q;
  assign tick           = tick_q;

endmodule
